// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-counter sequence checker.
package ring_pkg;

    // Width of the binary phase index decoded from the 4-bit one-hot ring.
    localparam int PHASE_W = 2;

    // Checker FSM states.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        ERROR  = 2'd2
    } state_e;

    // Error codes reported on err_code.
    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_NOT_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_BAD_STEP   = 2'b10;

    // Next legal ring value: 0001 -> 1000 -> 0100 -> 0010 -> 0001.
    function automatic logic [3:0] ring_rotate(input logic [3:0] cur);
        return {cur[0], cur[3:1]};
    endfunction

endpackage

// File: rtl/ring_onehot_dec.sv
// Combinational one-hot ring decoder: flags one-hot validity and maps the
// phase to its binary index (0001=0, 1000=1, 0100=2, 0010=3).
module ring_onehot_dec
    import ring_pkg::*;
(
    input  logic [3:0]         i_ring,
    output logic               o_onehot_ok,
    output logic [PHASE_W-1:0] o_idx
);

    // Decode the four legal codes; anything else is reported as not one-hot.
    always_comb begin
        o_onehot_ok = 1'b0;
        o_idx       = '0;
        case (i_ring)
            4'b0001: begin o_onehot_ok = 1'b1; o_idx = 2'd0; end
            4'b1000: begin o_onehot_ok = 1'b1; o_idx = 2'd1; end
            4'b0100: begin o_onehot_ok = 1'b1; o_idx = 2'd2; end
            4'b0010: begin o_onehot_ok = 1'b1; o_idx = 2'd3; end
            default: begin o_onehot_ok = 1'b0; o_idx = '0;   end
        endcase
    end

endmodule

// File: rtl/ring_seq_checker.sv
// Ring counter sequence checker: decodes the one-hot phase, hunts for lock,
// counts revolutions while locked and latches the first sequence fault.
// Optional macro RING_ERR_CNT_EN adds err_cnt, a saturating count of faults
// detected while locked (cleared by clr_err and rst).
module ring_seq_checker
    import ring_pkg::*;
#(
    parameter int REV_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         ring,
    input  logic               ring_vld,
    input  logic               clr_err,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_vld,
    output logic               locked,
    output logic [REV_W-1:0]   rev_cnt,
    output logic               rev_tick,
    output logic               err,
    output logic [1:0]         err_code
`ifdef RING_ERR_CNT_EN
    ,
    output logic [7:0]         err_cnt
`endif
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    logic               w_onehot;
    logic [PHASE_W-1:0] w_idx;
    logic               w_step_ok;
    logic [3:0]         w_good_inc;
    logic [1:0]         w_fault_code;

    state_e             r_state;
    logic [PHASE_W-1:0] r_phase;
    logic               r_phase_vld;
    logic               r_locked;
    logic [REV_W-1:0]   r_rev_cnt;
    logic               r_rev_tick;
    logic               r_err;
    logic [1:0]         r_err_code;
    logic [3:0]         r_prev;
    logic               r_prev_vld;
    logic [3:0]         r_good;
`ifdef RING_ERR_CNT_EN
    logic [7:0]         r_err_cnt;

    // Fault counter stops at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
`endif

    ring_onehot_dec u_dec (
        .i_ring      (ring),
        .o_onehot_ok (w_onehot),
        .o_idx       (w_idx)
    );

    // A step is legal only against a remembered one-hot sample; a stall fails.
    assign w_step_ok    = r_prev_vld && w_onehot && (ring == ring_rotate(r_prev));
    assign w_good_inc   = r_good + 4'd1;
    // Not-one-hot outranks a bad step when both apply.
    assign w_fault_code = w_onehot ? ERR_BAD_STEP : ERR_NOT_ONEHOT;

    // Sample tracking, lock FSM, revolution counting and error capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= HUNT;
            r_phase     <= '0;
            r_phase_vld <= 1'b0;
            r_locked    <= 1'b0;
            r_rev_cnt   <= '0;
            r_rev_tick  <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_prev      <= 4'b0000;
            r_prev_vld  <= 1'b0;
            r_good      <= 4'd0;
`ifdef RING_ERR_CNT_EN
            r_err_cnt   <= 8'd0;
`endif
        end else begin
            r_rev_tick <= 1'b0;

            // Every valid one-hot sample becomes the new phase and step reference.
            if (ring_vld && w_onehot) begin
                r_phase     <= w_idx;
                r_phase_vld <= 1'b1;
                r_prev      <= ring;
                r_prev_vld  <= 1'b1;
            end

            if (clr_err) begin
                // Clear wins over any fault seen this cycle; rev_cnt is kept.
                r_state    <= HUNT;
                r_locked   <= 1'b0;
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
                r_good     <= 4'd0;
                r_prev_vld <= 1'b0;
`ifdef RING_ERR_CNT_EN
                r_err_cnt  <= 8'd0;
`endif
            end else if (ring_vld) begin
                unique case (r_state)
                    HUNT: begin
                        if (w_step_ok) begin
                            if (w_good_inc >= LOCK_TGT) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                                r_good   <= 4'd0;
                            end else begin
                                r_good <= w_good_inc;
                            end
                        end else begin
                            r_good <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (!w_step_ok) begin
                            r_state    <= ERROR;
                            r_locked   <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_code <= w_fault_code;
`ifdef RING_ERR_CNT_EN
                            r_err_cnt  <= sat_inc8(r_err_cnt);
`endif
                        end else if (w_idx == '0) begin
                            // Phase 3 -> 0 closes one revolution; counter wraps freely.
                            r_rev_cnt  <= r_rev_cnt + 1'b1;
                            r_rev_tick <= 1'b1;
                        end
                    end
                    ERROR: begin
                        // First fault stays latched until clr_err.
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                        r_err    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign phase     = r_phase;
    assign phase_vld = r_phase_vld;
    assign locked    = r_locked;
    assign rev_cnt   = r_rev_cnt;
    assign rev_tick  = r_rev_tick;
    assign err       = r_err;
    assign err_code  = r_err_code;
`ifdef RING_ERR_CNT_EN
    assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_ring_seq_checker.sv
// Scoreboard bench for ring_seq_checker (REV_W=2, LOCK_CNT=2).
module tb_ring_seq_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ring;
    logic       ring_vld;
    logic       clr_err;
    logic [1:0] phase;
    logic       phase_vld;
    logic       locked;
    logic [1:0] rev_cnt;
    logic       rev_tick;
    logic       err;
    logic [1:0] err_code;
`ifdef RING_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_err = 0;
    int n_chk = 0;
    int vec_id = 0;

    localparam logic [3:0] A = 4'b0001;
    localparam logic [3:0] B = 4'b1000;
    localparam logic [3:0] C = 4'b0100;
    localparam logic [3:0] D = 4'b0010;

    typedef struct packed {
        logic [15:0] id;
        logic [9:0]  v;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    ring_seq_checker #(.REV_W(2), .LOCK_CNT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ring      (ring),
        .ring_vld  (ring_vld),
        .clr_err   (clr_err),
        .phase     (phase),
        .phase_vld (phase_vld),
        .locked    (locked),
        .rev_cnt   (rev_cnt),
        .rev_tick  (rev_tick),
        .err       (err),
        .err_code  (err_code)
`ifdef RING_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    logic [9:0] act_vec;
    assign act_vec = {phase, phase_vld, locked, rev_cnt, rev_tick, err, err_code};

    function automatic logic [9:0] E(input logic [1:0] ph, input logic pv, input logic lk,
                                     input logic [1:0] rv, input logic tk, input logic er,
                                     input logic [1:0] cd);
        return {ph, pv, lk, rv, tk, er, cd};
    endfunction

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%b want=%b (ph,pv,lk,rev,tick,err,code)", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic step(input logic v, input logic [3:0] r, input logic c, input logic [9:0] exp);
        exp_t e;
        @(negedge clk);
        ring_vld = v;
        ring     = r;
        clr_err  = c;
        vec_id++;
        e.id = 16'(vec_id);
        e.v  = exp;
        q.push_back(e);
    endtask

    // Monitor: compare registered outputs just after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check($sformatf("vec%0d", e.id), act_vec, e.v);
            end
        end
    end

    initial begin
        rst = 1'b0; ring = 4'b0000; ring_vld = 1'b0; clr_err = 1'b0;
        #1;
        check("reset_now", act_vec, 10'd0);
        step(1, A, 0, 10'd0);
        step(1, B, 0, 10'd0);
        @(posedge clk); #2; rst = 1'b1;

        // Lock and count revolutions, including the 3 -> 0 wrap of a 2-bit counter.
        step(1, A, 0, E(0,1,0,0,0,0,0));
        step(1, B, 0, E(1,1,0,0,0,0,0));
        step(1, C, 0, E(2,1,1,0,0,0,0));
        step(1, D, 0, E(3,1,1,0,0,0,0));
        step(1, A, 0, E(0,1,1,1,1,0,0));
        step(1, B, 0, E(1,1,1,1,0,0,0));
        step(1, C, 0, E(2,1,1,1,0,0,0));
        step(1, D, 0, E(3,1,1,1,0,0,0));
        step(1, A, 0, E(0,1,1,2,1,0,0));
        step(1, B, 0, E(1,1,1,2,0,0,0));
        step(1, C, 0, E(2,1,1,2,0,0,0));
        step(1, D, 0, E(3,1,1,2,0,0,0));
        step(1, A, 0, E(0,1,1,3,1,0,0));
        step(1, B, 0, E(1,1,1,3,0,0,0));
        step(1, C, 0, E(2,1,1,3,0,0,0));
        step(1, D, 0, E(3,1,1,3,0,0,0));
        step(1, A, 0, E(0,1,1,0,1,0,0));
        step(1, B, 0, E(1,1,1,0,0,0,0));
        step(1, C, 0, E(2,1,1,0,0,0,0));
        step(1, D, 0, E(3,1,1,0,0,0,0));
        step(1, A, 0, E(0,1,1,1,1,0,0));

        // Gap of invalid samples: everything holds, then resume in sequence.
        step(1, B, 0, E(1,1,1,1,0,0,0));
        for (int i = 0; i < 5; i++) step(0, 4'b1111, 0, E(1,1,1,1,0,0,0));
        step(1, C, 0, E(2,1,1,1,0,0,0));
        step(1, D, 0, E(3,1,1,1,0,0,0));

        // Not one-hot while locked; later fault and one-hot sample keep code 01.
        step(1, 4'b0011, 0, E(3,1,0,1,0,1,1));
        step(1, 4'b0110, 0, E(3,1,0,1,0,1,1));
`ifdef RING_ERR_CNT_EN
        @(posedge clk); #2;
        check("err_cnt_one", {2'b00, err_cnt}, 10'd1);
`endif
        step(1, A, 0, E(0,1,0,1,0,1,1));
        step(0, A, 1, E(0,1,0,1,0,0,0));
`ifdef RING_ERR_CNT_EN
        @(posedge clk); #2;
        check("err_cnt_clr", {2'b00, err_cnt}, 10'd0);
`endif
        step(1, A, 0, E(0,1,0,1,0,0,0));
        step(1, B, 0, E(1,1,0,1,0,0,0));
        step(1, C, 0, E(2,1,1,1,0,0,0));

        // Stall while locked -> bad step.
        step(1, D, 0, E(3,1,1,1,0,0,0));
        step(1, A, 0, E(0,1,1,2,1,0,0));
        step(1, B, 0, E(1,1,1,2,0,0,0));
        step(1, C, 0, E(2,1,1,2,0,0,0));
        step(1, C, 0, E(2,1,0,2,0,1,2));
        step(0, C, 1, E(2,1,0,2,0,0,0));

        // Skip 0001 -> 0100 while locked -> bad step.
        step(1, A, 0, E(0,1,0,2,0,0,0));
        step(1, B, 0, E(1,1,0,2,0,0,0));
        step(1, C, 0, E(2,1,1,2,0,0,0));
        step(1, D, 0, E(3,1,1,2,0,0,0));
        step(1, A, 0, E(0,1,1,3,1,0,0));
        step(1, C, 0, E(2,1,0,3,0,1,2));
        step(0, C, 1, E(2,1,0,3,0,0,0));

        // clr_err together with a fault: no error recorded, back to HUNT.
        step(1, A, 0, E(0,1,0,3,0,0,0));
        step(1, B, 0, E(1,1,0,3,0,0,0));
        step(1, C, 0, E(2,1,1,3,0,0,0));
        step(1, D, 0, E(3,1,1,3,0,0,0));
        step(1, 4'b0011, 1, E(3,1,0,3,0,0,0));

        // HUNT: non-one-hot resets the good count without raising an error.
        step(1, A, 0, E(0,1,0,3,0,0,0));
        step(1, B, 0, E(1,1,0,3,0,0,0));
        step(1, 4'b0101, 0, E(1,1,0,3,0,0,0));
        step(1, C, 0, E(2,1,0,3,0,0,0));
        step(1, D, 0, E(3,1,1,3,0,0,0));
        step(1, A, 0, E(0,1,1,0,1,0,0));
        step(1, B, 0, E(1,1,1,0,0,0,0));

        // Asynchronous reset mid-revolution.
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("async_rst", act_vec, 10'd0);
        step(1, C, 0, 10'd0);
        @(posedge clk); #2; rst = 1'b1;
        step(1, B, 0, E(1,1,0,0,0,0,0));
        step(1, C, 0, E(2,1,0,0,0,0,0));
        step(1, D, 0, E(3,1,1,0,0,0,0));

        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
